latch_bank_ctrl: RTL and testbench

//  Write controller/arbiter for a bank of 2**ADDR_W level-sensitive D-latch words (d_latch cells).
//  Two requesters (A, B) share the bank; the controller picks one round-robin and captures its address and data.
//  It then sequences the write: data setup, a one-hot enable pulse, then data hold.
//  The latch bank never sees D change while any En is high.

---
 rtl/latch_bank_ctrl_pkg.sv | 28 ++
 rtl/latch_bank_ctrl_phase_timer.sv | 29 ++
 rtl/latch_bank_ctrl.sv | 132 +++++++++++++
 tb/tb_latch_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_ctrl_pkg.sv
// Shared definitions for the latch bank write controller: FSM state
// encodings, requester IDs and elaboration-time sizing helpers.
package latch_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } ctrlStateT;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } reqIdT;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter holds duration-1 down to 0, so maxVal distinct values are needed.
  function automatic int cntWidth(input int maxVal);
    return (maxVal <= 2) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_phase_timer.sv
// Loadable down-counter timing each write phase; Expire flags the last
// cycle of the phase so the FSM can advance on the following edge.
module phase_timer #(
  parameter int CntW = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Load,
  input  logic [CntW-1:0] LoadVal,
  output logic            Expire
);

  logic [CntW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign Expire = (count == '0);

endmodule

// File: rtl/latch_bank_ctrl.sv
// Round-robin write arbiter for a bank of D-latch words; sequences each
// write as setup, one-hot enable pulse, hold, then a single-cycle Ack.
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 ReqA,
  input  logic [ADDR_W-1:0]    AddrA,
  input  logic [WIDTH-1:0]     DataA,
  input  logic                 ReqB,
  input  logic [ADDR_W-1:0]    AddrB,
  input  logic [WIDTH-1:0]     DataB,
  output logic                 AckA,
  output logic                 AckB,
  output logic [2**ADDR_W-1:0] LatchEn,
  output logic [WIDTH-1:0]     LatchD,
  output logic                 Busy
);

  localparam int Depth = 2**ADDR_W;
  localparam int CntW  = cntWidth(maxOf3(SETUP_CYC, EN_CYC, HOLD_CYC));

  ctrlStateT         state, stateNext;
  reqIdT             grantId, grantNext;
  reqIdT             lastWinner, lastWinnerNext;
  logic [ADDR_W-1:0] capAddr, capAddrNext;
  logic [Depth-1:0]  enNext;
  logic [WIDTH-1:0]  dNext;
  logic              ackANext, ackBNext;
  logic              timerLoad, timerExpire;
  logic [CntW-1:0]   timerVal;
  logic              eligA, eligB, pickB;

  // A requester whose Ack is still up is finishing, not asking again.
  assign eligA = ReqA && !AckA;
  assign eligB = ReqB && !AckB;
  assign pickB = eligB && (!eligA || (lastWinner == REQ_A));

  phase_timer #(.CntW(CntW)) u_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .Load    (timerLoad),
    .LoadVal (timerVal),
    .Expire  (timerExpire)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext      = state;
    grantNext      = grantId;
    lastWinnerNext = lastWinner;
    capAddrNext    = capAddr;
    dNext          = LatchD;
    enNext         = '0;
    ackANext       = 1'b0;
    ackBNext       = 1'b0;
    timerLoad      = 1'b0;
    timerVal       = '0;

    case (state)
      IDLE: begin
        if (eligA || eligB) begin
          grantNext      = pickB ? REQ_B : REQ_A;
          lastWinnerNext = pickB ? REQ_B : REQ_A;
          capAddrNext    = pickB ? AddrB : AddrA;
          dNext          = pickB ? DataB : DataA;
          stateNext      = SETUP;
          timerLoad      = 1'b1;
          timerVal       = CntW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (timerExpire) begin
          stateNext       = ENABLE;
          enNext[capAddr] = 1'b1;
          timerLoad       = 1'b1;
          timerVal        = CntW'(EN_CYC - 1);
        end
      end
      ENABLE: begin
        if (timerExpire) begin
          stateNext = HOLD;
          timerLoad = 1'b1;
          timerVal  = CntW'(HOLD_CYC - 1);
        end else begin
          enNext[capAddr] = 1'b1;
        end
      end
      HOLD: begin
        if (timerExpire) begin
          stateNext = IDLE;
          ackANext  = (grantId == REQ_A);
          ackBNext  = (grantId == REQ_B);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      grantId    <= REQ_A;
      lastWinner <= REQ_B;
      capAddr    <= '0;
      LatchEn    <= '0;
      LatchD     <= '0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      grantId    <= grantNext;
      lastWinner <= lastWinnerNext;
      capAddr    <= capAddrNext;
      LatchEn    <= enNext;
      LatchD     <= dNext;
      AckA       <= ackANext;
      AckB       <= ackBNext;
      Busy       <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl: default instance plus a 3/1/2 timing
// instance, with a free-running setup/hold and one-hot monitor.
module tb_latch_bank_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       ReqA, ReqB, AckA, AckB, Busy;
  logic [1:0] AddrA, AddrB;
  logic [7:0] DataA, DataB, LatchD;
  logic [3:0] LatchEn;

  logic       ReqAP, ReqBP, AckAP, AckBP, BusyP;
  logic [1:0] AddrAP, AddrBP;
  logic [7:0] DataAP, DataBP, LatchDP;
  logic [3:0] LatchEnP;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 Clk = ~Clk;

  latch_bank_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA),
    .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB),
    .AckA(AckA), .AckB(AckB), .LatchEn(LatchEn), .LatchD(LatchD), .Busy(Busy)
  );

  latch_bank_ctrl #(.SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) dutP (
    .Clk(Clk), .Rst(Rst),
    .ReqA(ReqAP), .AddrA(AddrAP), .DataA(DataAP),
    .ReqB(ReqBP), .AddrB(AddrBP), .DataB(DataBP),
    .AckA(AckAP), .AckB(AckBP), .LatchEn(LatchEnP), .LatchD(LatchDP), .Busy(BusyP)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Bounded wait for an Ack; which: 0 = dut A, 1 = dut B, 2 = dutP A.
  task automatic waitAck(input int which, output int cyc);
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      seen = (which == 0) ? AckA : (which == 1) ? AckB : AckAP;
    end
    if (!seen) cyc = -1;
  endtask

  task automatic test_setup_hold();
    logic [3:0] prevEn;
    logic [7:0] prevD;
    logic       prevRst;
    @(negedge Clk);
    prevEn = LatchEn; prevD = LatchD; prevRst = Rst;
    forever begin
      @(negedge Clk);
      totalCnt++;
      if ($onehot0(LatchEn) !== 1'b1 || $onehot0(LatchEnP) !== 1'b1)
        $display("FAIL onehot: LatchEn=%b LatchEnP=%b required at most one bit", LatchEn, LatchEnP);
      else passCnt++;
      if (!Rst && !prevRst && (LatchEn != 4'b0 || prevEn != 4'b0)) begin
        totalCnt++;
        if (LatchD !== prevD)
          $display("FAIL data_stable: LatchD=%h required %h (En %b->%b)", LatchD, prevD, prevEn, LatchEn);
        else passCnt++;
      end
      prevEn = LatchEn; prevD = LatchD; prevRst = Rst;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    ReqA = 0; AddrA = 0; DataA = 0; ReqB = 0; AddrB = 0; DataB = 0;
    ReqAP = 0; AddrAP = 0; DataAP = 0; ReqBP = 0; AddrBP = 0; DataBP = 0;
    repeat (2) @(posedge Clk);
    #1;
    totalCnt++;
    if ({LatchEn, LatchD, AckA, AckB, Busy} !== 15'h0)
      $display("FAIL reset_outputs: got %h required 0", {LatchEn, LatchD, AckA, AckB, Busy});
    else passCnt++;
    totalCnt++;
    if ({LatchEnP, LatchDP, AckAP, AckBP, BusyP} !== 15'h0)
      $display("FAIL reset_outputs_p: got %h required 0", {LatchEnP, LatchDP, AckAP, AckBP, BusyP});
    else passCnt++;
    Rst = 1'b0;
    tick(); tick();
    totalCnt++;
    if ({LatchEn, Busy} !== 5'h0)
      $display("FAIL post_reset_idle: got %b required 0", {LatchEn, Busy});
    else passCnt++;
  endtask

  // Also covers requester stability: ReqA stays up through the Ack cycle.
  task automatic test_single_write();
    logic [6:0] exp [7];
    exp = '{7'b0000001, 7'b0100001, 7'b0100001, 7'b0000001,
            7'b0000100, 7'b0000000, 7'b0000000};
    ReqA = 1; AddrA = 2'd2; DataA = 8'hA5;
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j == 0) begin AddrA = 2'd0; DataA = 8'h5A; end
      totalCnt++;
      if ({LatchEn, AckA, AckB, Busy} !== exp[j])
        $display("FAIL single_write[%0d]: {En,AckA,AckB,Busy}=%b required %b", j, {LatchEn, AckA, AckB, Busy}, exp[j]);
      else passCnt++;
      totalCnt++;
      if (LatchD !== 8'hA5)
        $display("FAIL single_data[%0d]: LatchD=%h required a5", j, LatchD);
      else passCnt++;
      if (j == 5) ReqA = 0;
    end
  endtask

  task automatic test_tie();
    logic [6:0] exp  [11];
    logic [7:0] expD [11];
    int cyc;
    exp  = '{7'b0000001, 7'b0010001, 7'b0010001, 7'b0000001, 7'b0000100, 7'b0000001,
             7'b1000001, 7'b1000001, 7'b0000001, 7'b0000010, 7'b0000000};
    expD = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
    Rst = 1'b1; tick(); Rst = 1'b0; tick();
    ReqA = 1; AddrA = 2'd1; DataA = 8'h11;
    ReqB = 1; AddrB = 2'd3; DataB = 8'h22;
    for (int j = 0; j < 11; j++) begin
      tick();
      totalCnt++;
      if ({LatchEn, AckA, AckB, Busy} !== exp[j] || LatchD !== expD[j])
        $display("FAIL tie[%0d]: {En,AckA,AckB,Busy}=%b D=%h required %b D=%h",
                 j, {LatchEn, AckA, AckB, Busy}, LatchD, exp[j], expD[j]);
      else passCnt++;
      if (j == 5) ReqA = 0;
      if (j == 10) ReqB = 0;
    end

    // B won last, so a fresh tie goes to A.
    ReqA = 1; AddrA = 2'd0; DataA = 8'h33;
    ReqB = 1; AddrB = 2'd2; DataB = 8'h44;
    tick();
    totalCnt++;
    if (LatchD !== 8'h33) $display("FAIL tie2_winner: LatchD=%h required 33", LatchD);
    else passCnt++;
    waitAck(0, cyc);
    totalCnt++;
    if (cyc !== 4) $display("FAIL tie2_ackA_latency: cycles=%0d required 4", cyc);
    else passCnt++;
    tick(); ReqA = 0;
    totalCnt++;
    if (LatchD !== 8'h44) $display("FAIL tie2_b_grant: LatchD=%h required 44", LatchD);
    else passCnt++;
    waitAck(1, cyc);
    tick(); ReqB = 0;

    // After a lone A write, a tie goes to B.
    ReqA = 1; AddrA = 2'd3; DataA = 8'h55;
    waitAck(0, cyc);
    tick(); ReqA = 0;
    ReqA = 1; AddrA = 2'd1; DataA = 8'h66;
    ReqB = 1; AddrB = 2'd0; DataB = 8'h77;
    tick();
    totalCnt++;
    if (LatchD !== 8'h77) $display("FAIL tie3_winner: LatchD=%h required 77", LatchD);
    else passCnt++;
    waitAck(1, cyc);
    tick(); ReqB = 0;
    totalCnt++;
    if (LatchD !== 8'h66) $display("FAIL tie3_a_grant: LatchD=%h required 66", LatchD);
    else passCnt++;
    waitAck(0, cyc);
    totalCnt++;
    if (cyc !== 4) $display("FAIL tie3_ackA_latency: cycles=%0d required 4", cyc);
    else passCnt++;
    tick(); ReqA = 0;
  endtask

  task automatic test_mid_reset();
    logic ackSeen;
    int   cyc;
    ReqA = 1; AddrA = 2'd0; DataA = 8'h99;
    tick(); tick();
    totalCnt++;
    if (LatchEn !== 4'b0001) $display("FAIL midrst_enable: LatchEn=%b required 0001", LatchEn);
    else passCnt++;
    #2 Rst = 1'b1;
    #1;
    totalCnt++;
    if ({LatchEn, Busy} !== 5'b0)
      $display("FAIL midrst_async: {En,Busy}=%b required 0", {LatchEn, Busy});
    else passCnt++;
    ReqA = 0;
    @(posedge Clk); #1 Rst = 1'b0;
    ackSeen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      ackSeen = ackSeen | AckA | AckB | Busy;
    end
    totalCnt++;
    if (ackSeen !== 1'b0) $display("FAIL midrst_no_ack: activity=%b required 0", ackSeen);
    else passCnt++;
    ReqB = 1; AddrB = 2'd1; DataB = 8'hB4;
    tick();
    totalCnt++;
    if ({LatchD, Busy} !== {8'hB4, 1'b1})
      $display("FAIL midrst_b_grant: D=%h Busy=%b required b4 1", LatchD, Busy);
    else passCnt++;
    waitAck(1, cyc);
    totalCnt++;
    if (cyc !== 4) $display("FAIL midrst_ackB_latency: cycles=%0d required 4", cyc);
    else passCnt++;
    tick(); ReqB = 0;
  endtask

  task automatic test_param_sweep();
    logic [6:0] exp [9];
    exp = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b1000001, 7'b0000001,
            7'b0000001, 7'b0000100, 7'b0000000, 7'b0000000};
    ReqAP = 1; AddrAP = 2'd3; DataAP = 8'hC3;
    for (int j = 0; j < 9; j++) begin
      tick();
      totalCnt++;
      if ({LatchEnP, AckAP, AckBP, BusyP} !== exp[j] || LatchDP !== 8'hC3)
        $display("FAIL sweep[%0d]: {En,AckA,AckB,Busy}=%b D=%h required %b D=c3",
                 j, {LatchEnP, AckAP, AckBP, BusyP}, LatchDP, exp[j]);
      else passCnt++;
      if (j == 7) ReqAP = 0;
    end
  endtask

  initial begin
    Rst = 1'b1;
    fork
      test_setup_hold();
    join_none
    test_reset();
    test_single_write();
    test_tie();
    test_mid_reset();
    test_param_sweep();
    tick();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
